// File: rtl/ram_march_bist.sv
// March C- BIST controller sitting in front of a single-port RAM; passes the functional port through when idle.
// Optional build macro BIST_ERR_CNT_EN: adds err_cnt and runs the full march instead of aborting on the first mismatch.
module ram_march_bist #(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [2:0]        fail_elem,
`ifdef BIST_ERR_CNT_EN
    output logic [7:0]        err_cnt,
`endif
    input  logic              func_cs_n,
    input  logic              func_we_n,
    input  logic [ADDR_W-1:0] func_addr,
    input  logic [WIDTH-1:0]  func_wdata,
    output logic [WIDTH-1:0]  func_rdata,
    output logic              ram_cs_n,
    output logic              ram_we_n,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [WIDTH-1:0]  ram_wdata,
    input  logic [WIDTH-1:0]  ram_rdata
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [2:0] M0 = 3'd0;
    localparam logic [2:0] M1 = 3'd1;
    localparam logic [2:0] M2 = 3'd2;
    localparam logic [2:0] M3 = 3'd3;
    localparam logic [2:0] M4 = 3'd4;
    localparam logic [2:0] M5 = 3'd5;
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(DEPTH - 1);

    state_t              state;
    state_t              state_nxt;
    logic [2:0]          elem;
    logic [ADDR_W-1:0]   addr;
    logic                phase;
    logic [WIDTH-1:0]    exp_data;
    logic                compare;
    logic                mismatch;
    logic                last_addr;
    logic                run_end;
    logic                abort;
    logic                start_run;

    assign func_rdata = ram_rdata;

    // phase 0 is the issue cycle of a read element, phase 1 its compare/write cycle
    always_comb begin
        compare   = (state == RUN) && phase && (elem != M0);
        exp_data  = ((elem == M2) || (elem == M4)) ? '1 : '0;
        mismatch  = compare && (ram_rdata != exp_data);
        last_addr = ((elem == M3) || (elem == M4)) ? (addr == '0) : (addr == ADDR_LAST);
        run_end   = compare && (elem == M5) && last_addr;
        start_run = (state != RUN) && start;
`ifdef BIST_ERR_CNT_EN
        abort     = 1'b0;
`else
        abort     = mismatch;
`endif
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: if (start) state_nxt = RUN;
            RUN:        if (run_end || abort) state_nxt = DONE;
            default:    state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == RUN);
        if (state == RUN) begin
            ram_cs_n  = (elem == M5) && phase;
            ram_we_n  = !((elem == M0) || (phase && (elem != M5)));
            ram_addr  = addr;
            ram_wdata = ((elem == M1) || (elem == M3)) ? '1 : '0;
        end else begin
            ram_cs_n  = func_cs_n;
            ram_we_n  = func_we_n;
            ram_addr  = func_addr;
            ram_wdata = func_wdata;
        end
    end

    // Element M0 steps every cycle; the others step after their compare cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            elem      <= M0;
            addr      <= '0;
            phase     <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            fail_addr <= '0;
            fail_elem <= 3'd0;
`ifdef BIST_ERR_CNT_EN
            err_cnt   <= 8'd0;
`endif
        end else if (start_run) begin
            elem      <= M0;
            addr      <= '0;
            phase     <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            fail_addr <= '0;
            fail_elem <= 3'd0;
`ifdef BIST_ERR_CNT_EN
            err_cnt   <= 8'd0;
`endif
        end else if (state == RUN) begin
            if ((elem == M0) || phase) begin
                phase <= 1'b0;
                if (last_addr && (elem != M5)) begin
                    elem <= elem + 3'd1;
                    addr <= ((elem == M2) || (elem == M3)) ? '1 : '0;
                end else if ((elem == M3) || (elem == M4)) begin
                    addr <= addr - ADDR_W'(1);
                end else begin
                    addr <= addr + ADDR_W'(1);
                end
            end else begin
                phase <= 1'b1;
            end
`ifdef BIST_ERR_CNT_EN
            if (mismatch && (err_cnt == 8'd0)) begin
                fail_addr <= addr;
                fail_elem <= elem;
            end
            if (mismatch && (err_cnt != 8'hFF)) begin
                err_cnt <= err_cnt + 8'd1;
            end
            if (run_end) begin
                done <= 1'b1;
                pass <= (err_cnt == 8'd0) && !mismatch;
            end
`else
            if (mismatch) begin
                fail_addr <= addr;
                fail_elem <= elem;
            end
            if (run_end || abort) begin
                done <= 1'b1;
                pass <= !mismatch;
            end
`endif
        end
    end

endmodule

// File: tb/tb_ram_march_bist.sv
// Directed bench for ram_march_bist with a behavioural single-port RAM that can inject a stuck-at-1 bit.
// Expected values go through a scoreboard queue and are checked by immediate assertions.
module tb_ram_march_bist;

    localparam int WIDTH  = 8;
    localparam int DEPTH  = 8;
    localparam int ADDR_W = 3;

    logic              clk;
    logic              reset_n;
    logic              start;
    logic              busy;
    logic              done;
    logic              pass;
    logic [ADDR_W-1:0] fail_addr;
    logic [2:0]        fail_elem;
`ifdef BIST_ERR_CNT_EN
    logic [7:0]        err_cnt;
`endif
    logic              func_cs_n;
    logic              func_we_n;
    logic [ADDR_W-1:0] func_addr;
    logic [WIDTH-1:0]  func_wdata;
    logic [WIDTH-1:0]  func_rdata;
    logic              ram_cs_n;
    logic              ram_we_n;
    logic [ADDR_W-1:0] ram_addr;
    logic [WIDTH-1:0]  ram_wdata;
    logic [WIDTH-1:0]  ram_rdata;

    logic [WIDTH-1:0]  mem [DEPTH];
    logic              fault_en;

    typedef struct {
        string       tag;
        logic [31:0] value;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   edges;

    ram_march_bist #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .pass       (pass),
        .fail_addr  (fail_addr),
        .fail_elem  (fail_elem),
`ifdef BIST_ERR_CNT_EN
        .err_cnt    (err_cnt),
`endif
        .func_cs_n  (func_cs_n),
        .func_we_n  (func_we_n),
        .func_addr  (func_addr),
        .func_wdata (func_wdata),
        .func_rdata (func_rdata),
        .ram_cs_n   (ram_cs_n),
        .ram_we_n   (ram_we_n),
        .ram_addr   (ram_addr),
        .ram_wdata  (ram_wdata),
        .ram_rdata  (ram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Registered-read RAM; the fault forces bit 3 of word 5 high on every read.
    always @(posedge clk) begin
        if (!ram_cs_n) begin
            if (!ram_we_n) mem[ram_addr] <= ram_wdata;
            ram_rdata <= (fault_en && (ram_addr == 3'd5)) ? (mem[ram_addr] | 8'h08) : mem[ram_addr];
        end else begin
            ram_rdata <= '0;
        end
    end

    task automatic pushExpected(input string tag, input logic [31:0] value);
        exp_t e;
        e.tag   = tag;
        e.value = value;
        sb.push_back(e);
    endtask

    task automatic checkOutput(input logic [31:0] observed);
        exp_t e;
        assert (sb.size() != 0) else begin
            errors++;
            $error("[TB] FAIL scoreboard_empty: observed=%0h expected=none", observed);
        end
        if (sb.size() != 0) begin
            e = sb.pop_front();
            checks++;
            assert (observed === e.value) else begin
                errors++;
                $error("[TB] FAIL %s: observed=%0h expected=%0h", e.tag, observed, e.value);
            end
        end
    endtask

    // One-cycle start pulse; returns at the falling edge inside cycle 1 of the run.
    task automatic applyStimulus();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Counts edges after the start edge until done; optionally re-pulses start during cycle pokeAt.
    task automatic waitDone(input int pokeAt, output int n);
        n = 0;
        while (done !== 1'b1 && n < 300) begin
            start = (n == pokeAt - 1);
            @(negedge clk);
            n++;
        end
        start = 1'b0;
    endtask

    initial begin
        reset_n    = 1'b0;
        start      = 1'b0;
        fault_en   = 1'b0;
        func_cs_n  = 1'b1;
        func_we_n  = 1'b1;
        func_addr  = '0;
        func_wdata = '0;
        for (int i = 0; i < DEPTH; i++) mem[i] = 8'h5A;
        repeat (3) @(negedge clk);

        pushExpected("reset_busy", 0);      checkOutput(busy);
        pushExpected("reset_done", 0);      checkOutput(done);
        pushExpected("reset_pass", 0);      checkOutput(pass);
        pushExpected("reset_fail_addr", 0); checkOutput(fail_addr);
        pushExpected("reset_fail_elem", 0); checkOutput(fail_elem);
        reset_n = 1'b1;

        @(negedge clk);
        func_cs_n  = 1'b0;
        func_we_n  = 1'b0;
        func_addr  = 3'd2;
        func_wdata = 8'hA5;
        #1;
        pushExpected("mux_cs_n", 0);     checkOutput(ram_cs_n);
        pushExpected("mux_we_n", 0);     checkOutput(ram_we_n);
        pushExpected("mux_addr", 2);     checkOutput(ram_addr);
        pushExpected("mux_wdata", 8'hA5); checkOutput(ram_wdata);
        @(negedge clk);
        func_we_n = 1'b1;
        pushExpected("func_read_a5", 8'hA5);
        @(negedge clk);
        func_cs_n = 1'b1;
        checkOutput(func_rdata);

        applyStimulus();
        pushExpected("run1_busy_c1", 1); checkOutput(busy);
        waitDone(0, edges);
        pushExpected("run1_edges", 88); checkOutput(edges);
        pushExpected("run1_busy", 0);   checkOutput(busy);
        pushExpected("run1_pass", 1);   checkOutput(pass);
        for (int k = 0; k < DEPTH; k++) begin
            func_cs_n = 1'b0;
            func_we_n = 1'b1;
            func_addr = 3'(k);
            pushExpected($sformatf("readback_%0d", k), 0);
            @(negedge clk);
            checkOutput(func_rdata);
        end
        func_cs_n = 1'b1;

        fault_en = 1'b1;
        applyStimulus();
        waitDone(0, edges);
`ifdef BIST_ERR_CNT_EN
        pushExpected("fault_edges", 88); checkOutput(edges);
        pushExpected("fault_err_cnt", 3); checkOutput(err_cnt);
`else
        pushExpected("fault_edges", 20); checkOutput(edges);
`endif
        pushExpected("fault_done", 1);      checkOutput(done);
        pushExpected("fault_pass", 0);      checkOutput(pass);
        pushExpected("fault_fail_addr", 5); checkOutput(fail_addr);
        pushExpected("fault_fail_elem", 1); checkOutput(fail_elem);

        fault_en = 1'b0;
        applyStimulus();
        pushExpected("restart_done", 0);      checkOutput(done);
        pushExpected("restart_busy", 1);      checkOutput(busy);
        pushExpected("restart_pass", 0);      checkOutput(pass);
        pushExpected("restart_fail_addr", 0); checkOutput(fail_addr);
        pushExpected("restart_fail_elem", 0); checkOutput(fail_elem);
`ifdef BIST_ERR_CNT_EN
        pushExpected("restart_err_cnt", 0);   checkOutput(err_cnt);
`endif
        waitDone(10, edges);
        pushExpected("poke_edges", 88); checkOutput(edges);
        pushExpected("poke_pass", 1);   checkOutput(pass);

        applyStimulus();
        repeat (39) @(negedge clk);
        pushExpected("c40_busy", 1); checkOutput(busy);
        #2;
        reset_n   = 1'b0;
        func_cs_n = 1'b1;
        #1;
        pushExpected("async_busy", 0);     checkOutput(busy);
        pushExpected("async_done", 0);     checkOutput(done);
        pushExpected("async_pass", 0);     checkOutput(pass);
        pushExpected("async_cs_n_hi", 1);  checkOutput(ram_cs_n);
        func_cs_n = 1'b0;
        #1;
        pushExpected("async_cs_n_lo", 0);  checkOutput(ram_cs_n);
        func_cs_n = 1'b1;
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        pushExpected("post_reset_busy", 0); checkOutput(busy);
        pushExpected("post_reset_done", 0); checkOutput(done);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ram_march_bist.md
Name: ram_march_bist

Overview:
- March C- built-in self-test controller placed directly upstream of the single-port WIDTH x DEPTH RAM.
- Owns the RAM port (cs_n, we_n, addr, wdata) and consumes its registered read data.
- When idle, passes the functional port through to the RAM unchanged.
- Reports done/pass plus the address and march element of the first failure.

Parameters:
- WIDTH, 8, RAM data width.
- DEPTH, 8, number of RAM words.
- ADDR_W, 3, address width; DEPTH must equal 2**ADDR_W.

Ports:
- clk  input  1  clock.
- reset_n  input  1  asynchronous reset, active-low.
- start  input  1  start pulse; sampled only in IDLE or DONE.
- busy  output  1  high while the test owns the RAM.
- done  output  1  high from test end until the next start or reset.
- pass  output  1  valid when done=1; 1 means no mismatch.
- fail_addr  output  ADDR_W  address of the first mismatch.
- fail_elem  output  3  march element (0-5) of the first mismatch.
- func_cs_n  input  1  functional chip select, active-low.
- func_we_n  input  1  functional write enable, active-low.
- func_addr  input  ADDR_W  functional address.
- func_wdata  input  WIDTH  functional write data.
- func_rdata  output  WIDTH  wired directly to ram_rdata.
- ram_cs_n  output  1  RAM chip select.
- ram_we_n  output  1  RAM write enable.
- ram_addr  output  ADDR_W  RAM address.
- ram_wdata  output  WIDTH  RAM write data.
- ram_rdata  input  WIDTH  RAM data_out; registered, 1-cycle read latency, forced to 0 the cycle after cs_n is high.

Behaviour:
- Reset: clk and reset_n (asynchronous, active-low) as already decided. Reset forces state IDLE and busy=done=pass=0, fail_addr=0, fail_elem=0.
- Mux:
  - busy=0: ram_* = func_* combinationally.
  - busy=1: ram_* are decoded from state registers only; func_* are ignored.
- States: IDLE, RUN, DONE.
  - IDLE/DONE -> RUN on a clk edge with start=1. Entering RUN clears done, pass, fail_addr and fail_elem.
  - start while in RUN is ignored.
- March sequence, bg0 = all zeros, bg1 = all ones:
  - M0 up(w0), M1 up(r0,w1), M2 up(r1,w0), M3 down(r0,w1), M4 down(r1,w0), M5 up(r0).
  - up = addresses 0..DEPTH-1; down = DEPTH-1..0.
- Timing, with cycle 1 = the first cycle after the start edge:
  - Write-only element: 1 cycle per address (cs_n=0, we_n=0).
  - Read+write element: issue cycle (cs_n=0, we_n=1), then compare cycle. The compare cycle checks ram_rdata against the expected background and drives the write (cs_n=0, we_n=0, same address).
  - M5: issue cycle, then compare cycle with cs_n=1.
  - Total RUN length is 11*DEPTH cycles (88 at default).
  - At the edge ending the last compare: RUN -> DONE, done=1, pass=1 if no mismatch.
- Mismatch on a compare cycle:
  - The write of that cycle still occurs.
  - fail_addr and fail_elem are captured.
  - At that edge, RUN -> DONE with pass=0, done=1 (abort).
- Outputs busy, done, pass, fail_addr and fail_elem are registered; busy=1 exactly while in RUN.
- After a passing run, every RAM word holds 0.
- Address counters wrap with no carry into other logic. Element index saturates at 5.
- Reset mid-RUN: immediate IDLE with all outputs at reset values and the mux returned to functional. RAM contents are undefined.

Optional Feature:
- Macro BIST_ERR_CNT_EN.
- Defined:
  - Adds output err_cnt, 8 bits, reset 0, cleared on start.
  - err_cnt increments, saturating at 255, on every mismatching compare.
  - The test no longer aborts; it always runs 11*DEPTH cycles.
  - fail_addr and fail_elem still hold the first mismatch; pass=0 if err_cnt is nonzero at done.
- Undefined: no err_cnt port; the test aborts at the first mismatch.

Test Plan:
- Fault-free RAM model, 1-cycle start pulse -> busy=1 next cycle; done=1 and busy=0 after exactly 88 edges; pass=1; all 8 words read back 0x00 via the functional port.
- RAM model with addr 5 bit 3 stuck-at-1 -> mismatch on the M1 compare at cycle 20; done=1 after edge 20; pass=0, fail_addr=5, fail_elem=1.
- Idle, functional write 0xA5 to addr 2, then read addr 2 -> ram_* mirror func_*; func_rdata=0xA5 one cycle after the read.
- reset_n low at cycle 40 of RUN -> busy, done and pass go 0 without a clock edge; ram_cs_n follows func_cs_n.
- start pulsed at cycle 10 of RUN -> ignored, done still at edge 88. start in DONE -> done clears and a new 88-cycle run starts.
- BIST_ERR_CNT_EN defined, same stuck-at fault -> run completes at edge 88, err_cnt=3 (M1, M3, M5), fail_elem=1, fail_addr=5, pass=0.
